mt_rmq_tx_sched: RTL

- Round-robin scheduler that shares one remote-message-queue TX path (the mt_rmq_tx_path stream packer/framer) between g_num_slots outgoing queue slots.
- Grants the stream to one slot per packet.
- Drives the path's per-packet header parameters (MAC, ethertype, UDP/IP, payload length) from a per-slot config bank, holding them stable for the whole packet.
- Counts forwarded words and flags length mismatches.

---
 rtl/wrn_mqueue_pkg.sv | 39 +++
 rtl/mt_rr_arbiter.sv | 32 +++
 rtl/mt_rmq_tx_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wrn_mqueue_pkg.sv
// Shared remote-message-queue types: stream beat record, per-slot TX header
// config record, config register map and scheduler state encoding.
package wrn_mqueue_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [31:0] data;
  } t_rmq_stream_src_out;

  typedef struct packed {
    logic        use_udp;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } t_rmq_tx_slot_cfg;

  localparam logic [2:0] c_RMQ_CFG_MAC_HI = 3'd0;
  localparam logic [2:0] c_RMQ_CFG_MAC_LO = 3'd1;
  localparam logic [2:0] c_RMQ_CFG_DST_IP = 3'd2;
  localparam logic [2:0] c_RMQ_CFG_SRC_IP = 3'd3;
  localparam logic [2:0] c_RMQ_CFG_PORTS  = 3'd4;
  localparam logic [2:0] c_RMQ_CFG_TYPE   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP
  } t_rmq_sched_state;

  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mt_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo g_width.
module mt_rr_arbiter #(
  parameter int g_width = 4
) (
  input  logic [g_width-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic               gnt_valid_o,
  output logic [2:0]         gnt_idx_o
);

  logic found;
  int   cand;

  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = 0;
    for (int i = 0; i < g_width; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= g_width) cand = cand - g_width;
      for (int k = 0; k < g_width; k++) begin
        if (!found && req_i[k] && (cand == k)) begin
          found     = 1'b1;
          gnt_idx_o = 3'(k);
        end
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/mt_rmq_tx_sched.sv
// Round-robin scheduler sharing one RMQ TX path between g_num_slots queue
// slots; one packet per grant, header parameters frozen from SETUP on.
module mt_rmq_tx_sched
  import wrn_mqueue_pkg::*;
#(
  parameter int g_num_slots  = 4,
  parameter int g_gap_cycles = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [g_num_slots-1:0]    slot_valid_i,
  input  logic [g_num_slots-1:0]    slot_last_i,
  input  logic [32*g_num_slots-1:0] slot_data_i,
  input  logic [16*g_num_slots-1:0] slot_words_i,
  output logic [g_num_slots-1:0]    slot_ready_o,
  output logic                      src_valid_o,
  output logic                      src_last_o,
  output logic [31:0]               src_data_o,
  input  logic                      src_ready_i,
  input  logic                      cfg_we_i,
  input  logic [2:0]                cfg_slot_i,
  input  logic [2:0]                cfg_addr_i,
  input  logic [31:0]               cfg_data_i,
  output logic                      p_use_udp_o,
  output logic [47:0]               p_dst_mac_o,
  output logic [15:0]               p_ethertype_o,
  output logic [31:0]               p_src_ip_o,
  output logic [31:0]               p_dst_ip_o,
  output logic [15:0]               p_src_port_o,
  output logic [15:0]               p_dst_port_o,
  output logic [15:0]               p_payload_words_o,
  output logic [2:0]                grant_o,
  output logic                      busy_o,
  output logic                      len_err_o
);

  t_rmq_sched_state state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  t_rmq_tx_slot_cfg cfg_q [g_num_slots];
  t_rmq_tx_slot_cfg cfg_d [g_num_slots];
  t_rmq_tx_slot_cfg p_cfg_q, p_cfg_d;
  logic [15:0]      p_words_q, p_words_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             len_err_q, len_err_d;

  logic                arb_valid;
  logic [2:0]          arb_idx;
  logic [15:0]         arb_words;
  t_rmq_tx_slot_cfg    arb_cfg;
  t_rmq_stream_src_out g_src;
  logic                xfer;
  logic                fire;
  logic [15:0]         cnt_inc;

  mt_rr_arbiter #(.g_width(g_num_slots)) u_arb (
    .req_i       (slot_valid_i),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  always_comb begin
    g_src     = '0;
    arb_words = '0;
    arb_cfg   = '0;
    for (int k = 0; k < g_num_slots; k++) begin
      if (grant_q == 3'(k)) begin
        g_src.valid = slot_valid_i[k];
        g_src.last  = slot_last_i[k];
        g_src.data  = slot_data_i[32*k +: 32];
      end
      if (arb_idx == 3'(k)) begin
        arb_words = slot_words_i[16*k +: 16];
        arb_cfg   = cfg_q[k];
      end
    end
  end

  // The granted slot is a pure combinational pass-through while in XFER.
  always_comb begin
    xfer         = (state_q == ST_XFER);
    src_valid_o  = xfer & g_src.valid;
    src_last_o   = xfer & g_src.valid & g_src.last;
    src_data_o   = xfer ? g_src.data : 32'd0;
    slot_ready_o = '0;
    for (int k = 0; k < g_num_slots; k++) begin
      if (xfer && (grant_q == 3'(k))) slot_ready_o[k] = src_ready_i;
    end
    fire    = src_valid_o & src_ready_i;
    cnt_inc = f_sat_inc16(word_cnt_q);
  end

  // Writes land in the bank only; the frozen p_cfg copy changes at grant.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we_i) begin
      for (int k = 0; k < g_num_slots; k++) begin
        if (cfg_slot_i == 3'(k)) begin
          case (cfg_addr_i)
            c_RMQ_CFG_MAC_HI: cfg_d[k].dst_mac[47:32] = cfg_data_i[15:0];
            c_RMQ_CFG_MAC_LO: cfg_d[k].dst_mac[31:0]  = cfg_data_i;
            c_RMQ_CFG_DST_IP: cfg_d[k].dst_ip         = cfg_data_i;
            c_RMQ_CFG_SRC_IP: cfg_d[k].src_ip         = cfg_data_i;
            c_RMQ_CFG_PORTS: begin
              cfg_d[k].src_port = cfg_data_i[31:16];
              cfg_d[k].dst_port = cfg_data_i[15:0];
            end
            c_RMQ_CFG_TYPE: begin
              cfg_d[k].use_udp   = cfg_data_i[16];
              cfg_d[k].ethertype = cfg_data_i[15:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    p_cfg_d    = p_cfg_q;
    p_words_d  = p_words_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    len_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_idx;
          p_cfg_d    = arb_cfg;
          p_words_d  = arb_words;
          word_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_XFER;
      ST_XFER: begin
        if (fire) begin
          word_cnt_d = cnt_inc;
          if (g_src.last) begin
            len_err_d = (cnt_inc != p_words_q);
            rr_ptr_d  = (grant_q == 3'(g_num_slots - 1)) ? 3'd0 : grant_q + 3'd1;
            if (g_gap_cycles == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = 4'(g_gap_cycles - 1);
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cfg_q      <= '{default: '0};
      p_cfg_q    <= '0;
      p_words_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cfg_q      <= cfg_d;
      p_cfg_q    <= p_cfg_d;
      p_words_q  <= p_words_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign p_use_udp_o       = p_cfg_q.use_udp;
  assign p_dst_mac_o       = p_cfg_q.dst_mac;
  assign p_ethertype_o     = p_cfg_q.ethertype;
  assign p_src_ip_o        = p_cfg_q.src_ip;
  assign p_dst_ip_o        = p_cfg_q.dst_ip;
  assign p_src_port_o      = p_cfg_q.src_port;
  assign p_dst_port_o      = p_cfg_q.dst_port;
  assign p_payload_words_o = p_words_q;
  assign grant_o           = grant_q;
  assign busy_o            = (state_q == ST_SETUP) || (state_q == ST_XFER);
  assign len_err_o         = len_err_q;

endmodule
